// File: rtl/nios2_dbg_pkg.sv
// Shared definitions for the Nios II debug virtual-JTAG link: scan FSM states,
// virtual IR instruction codes and the default data-register length.
package nios2_dbg_pkg;

   localparam int unsigned DR_WIDTH_DEFAULT = 38;

   localparam logic [1:0] IR_OCIMEM    = 2'b00;
   localparam logic [1:0] IR_TRACEMEM  = 2'b01;
   localparam logic [1:0] IR_BREAK     = 2'b10;
   localparam logic [1:0] IR_TRACECTRL = 2'b11;

   typedef enum logic [2:0] {
      StIdle,
      StUir,
      StCdr,
      StSdr,
      StUdr,
      StRti
   } vjtag_state_e;

endpackage

// File: rtl/vjtag_tck_gen.sv
// TCK divider: low for TCK_DIV clk cycles, then high for TCK_DIV cycles.
// tck_rise/tck_fall flag the cycle whose closing edge moves tck up/down.
module vjtag_tck_gen #(
   parameter int unsigned TCK_DIV = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   input  logic run,
   output logic tck,
   output logic tck_rise,
   output logic tck_fall
);

   localparam int unsigned CntW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tck_q, tck_d;
   logic            wrap;

   assign wrap     = run && (cnt_q == CntW'(TCK_DIV - 1));
   assign tck_rise = wrap && !tck_q;
   assign tck_fall = wrap && tck_q;
   assign tck      = tck_q;

   always_comb begin
      cnt_d = cnt_q;
      tck_d = tck_q;
      if (restart || !run) begin
         cnt_d = '0;
         tck_d = 1'b0;
      end else if (wrap) begin
         cnt_d = '0;
         tck_d = ~tck_q;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         tck_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tck_q <= tck_d;
      end
   end

endmodule

// File: rtl/nios2_debug_vjtag_driver.sv
// Initiator for the Nios II debug-slave virtual JTAG: one full IR/DR scan per command,
// returning the TDO word shifted out of the slave.
module nios2_debug_vjtag_driver
   import nios2_dbg_pkg::*;
#(
   parameter int unsigned TCK_DIV    = 2,
   parameter int unsigned DR_WIDTH   = DR_WIDTH_DEFAULT,
   parameter int unsigned IR_WIDTH   = 2,
   parameter int unsigned RTI_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_data,
   output logic                rsp_valid,
   output logic [DR_WIDTH-1:0] rsp_data,
   output logic [IR_WIDTH-1:0] rsp_ir_out,
   output logic                vji_tck,
   output logic                vji_tdi,
   input  logic                vji_tdo,
   output logic [IR_WIDTH-1:0] vji_ir_in,
   input  logic [IR_WIDTH-1:0] vji_ir_out,
   output logic                vji_uir,
   output logic                vji_cdr,
   output logic                vji_sdr,
   output logic                vji_udr,
   output logic                vji_rti
);

   // One counter serves both the SDR bit count and the RTI period count.
   localparam int unsigned CntMax = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

   vjtag_state_e        state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [DR_WIDTH-1:0] sr_q, sr_d;
   logic [DR_WIDTH-1:0] cap_q, cap_d;
   logic [DR_WIDTH-1:0] sr_shift;
   logic [DR_WIDTH:0]   cap_shift;
   logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
   logic [IR_WIDTH-1:0] ir_cap_q, ir_cap_d;
   logic [IR_WIDTH-1:0] rsp_ir_out_q, rsp_ir_out_d;
   logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic                tdi_q, tdi_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                uir_q, uir_d, cdr_q, cdr_d, sdr_q, sdr_d, udr_q, udr_d, rti_q, rti_d;
   logic                accept, tck_rise, tck_fall;

   assign accept    = cmd_valid && cmd_ready_q;
   assign sr_shift  = sr_q >> 1;
   assign cap_shift = {vji_tdo, cap_q};

   vjtag_tck_gen #(
      .TCK_DIV (TCK_DIV)
   ) u_tck_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .restart  (accept),
      .run      (state_q != StIdle),
      .tck      (vji_tck),
      .tck_rise (tck_rise),
      .tck_fall (tck_fall)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sr_d         = sr_q;
      cap_d        = cap_q;
      ir_in_d      = ir_in_q;
      ir_cap_d     = ir_cap_q;
      rsp_ir_out_d = rsp_ir_out_q;
      rsp_data_d   = rsp_data_q;
      rsp_valid_d  = 1'b0;
      tdi_d        = tdi_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               ir_in_d = cmd_ir;
               sr_d    = cmd_data;
               cnt_d   = '0;
               tdi_d   = 1'b0;
               state_d = StUir;
            end
         end
         StUir: begin
            if (tck_rise) ir_cap_d = vji_ir_out;
            if (tck_fall) state_d = StCdr;
         end
         StCdr: begin
            if (tck_fall) begin
               tdi_d   = sr_q[0];
               cnt_d   = '0;
               state_d = StSdr;
            end
         end
         StSdr: begin
            if (tck_rise) cap_d = cap_shift[DR_WIDTH:1];
            if (tck_fall) begin
               sr_d = sr_shift;
               if (cnt_q == CntW'(DR_WIDTH - 1)) begin
                  tdi_d   = 1'b0;
                  cnt_d   = '0;
                  state_d = StUdr;
               end else begin
                  tdi_d = sr_shift[0];
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StUdr: begin
            if (tck_fall) begin
               cnt_d   = '0;
               state_d = StRti;
            end
         end
         StRti: begin
            if (tck_fall) begin
               if (cnt_q == CntW'(RTI_CYCLES - 1)) begin
                  rsp_valid_d  = 1'b1;
                  rsp_data_d   = cap_q;
                  rsp_ir_out_d = ir_cap_q;
                  state_d      = StIdle;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Strobes are registered from the next state so they move with the tck fall.
      cmd_ready_d = (state_d == StIdle);
      uir_d       = (state_d == StUir);
      cdr_d       = (state_d == StCdr);
      sdr_d       = (state_d == StSdr);
      udr_d       = (state_d == StUdr);
      rti_d       = (state_d == StRti) || (state_d == StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         sr_q         <= '0;
         cap_q        <= '0;
         ir_in_q      <= '0;
         ir_cap_q     <= '0;
         rsp_ir_out_q <= '0;
         rsp_data_q   <= '0;
         rsp_valid_q  <= 1'b0;
         tdi_q        <= 1'b0;
         cmd_ready_q  <= 1'b1;
         uir_q        <= 1'b0;
         cdr_q        <= 1'b0;
         sdr_q        <= 1'b0;
         udr_q        <= 1'b0;
         rti_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sr_q         <= sr_d;
         cap_q        <= cap_d;
         ir_in_q      <= ir_in_d;
         ir_cap_q     <= ir_cap_d;
         rsp_ir_out_q <= rsp_ir_out_d;
         rsp_data_q   <= rsp_data_d;
         rsp_valid_q  <= rsp_valid_d;
         tdi_q        <= tdi_d;
         cmd_ready_q  <= cmd_ready_d;
         uir_q        <= uir_d;
         cdr_q        <= cdr_d;
         sdr_q        <= sdr_d;
         udr_q        <= udr_d;
         rti_q        <= rti_d;
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_data   = rsp_data_q;
   assign rsp_ir_out = rsp_ir_out_q;
   assign vji_tdi    = tdi_q;
   assign vji_ir_in  = ir_in_q;
   assign vji_uir    = uir_q;
   assign vji_cdr    = cdr_q;
   assign vji_sdr    = sdr_q;
   assign vji_udr    = udr_q;
   assign vji_rti    = rti_q;

endmodule

// File: tb/tb_nios2_debug_vjtag_driver.sv
// Directed bench for nios2_debug_vjtag_driver: default instance against a 38-bit slave
// model, plus a TCK_DIV=1 / DR_WIDTH=8 instance with tdi looped back to tdo.
module tb_nios2_debug_vjtag_driver;
   import nios2_dbg_pkg::*;

   localparam logic [37:0] SLV_CAP = 38'h2A_5A5A_5A5A;
   localparam logic [37:0] CMD1    = 38'h15_0F0F_F0F0;
   localparam logic [37:0] CMD2    = 38'h3C_1234_5678;
   localparam logic [37:0] CMD3    = 38'h01_DEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_ir;
   logic [37:0] cmd_data;
   logic        rsp_valid;
   logic [37:0] rsp_data;
   logic [1:0]  rsp_ir_out;
   logic        vji_tck, vji_tdi, vji_tdo;
   logic [1:0]  vji_ir_in;
   logic [1:0]  ir_status;
   logic        vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

   logic        cmd_valid_b;
   logic        cmd_ready_b;
   logic [1:0]  cmd_ir_b;
   logic [7:0]  cmd_data_b;
   logic        rsp_valid_b;
   logic [7:0]  rsp_data_b;
   logic [1:0]  rsp_ir_out_b;
   logic        vji_tck_b, vji_tdi_b;
   logic [1:0]  vji_ir_in_b;
   logic        uir_b, cdr_b, sdr_b, udr_b, rti_b;

   logic [37:0] slv_sr;
   logic [4:0]  strb;

   int checks = 0;
   int errors = 0;
   int n_uir, n_cdr, n_sdr, n_udr, n_rti, onehot_bad, tck_bad, ready_bad;

   always #5 clk = ~clk;

   assign strb    = {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti};
   assign vji_tdo = slv_sr[0];

   // Slave model: captures a fixed word at CDR, shifts tdi in at each SDR tck rise.
   always @(posedge vji_tck or negedge reset_n) begin
      if (!reset_n)     slv_sr <= '0;
      else if (vji_cdr) slv_sr <= SLV_CAP;
      else if (vji_sdr) slv_sr <= {vji_tdi, slv_sr[37:1]};
   end

   nios2_debug_vjtag_driver dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_ir     (cmd_ir),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_ir_out (rsp_ir_out),
      .vji_tck    (vji_tck),
      .vji_tdi    (vji_tdi),
      .vji_tdo    (vji_tdo),
      .vji_ir_in  (vji_ir_in),
      .vji_ir_out (ir_status),
      .vji_uir    (vji_uir),
      .vji_cdr    (vji_cdr),
      .vji_sdr    (vji_sdr),
      .vji_udr    (vji_udr),
      .vji_rti    (vji_rti)
   );

   nios2_debug_vjtag_driver #(
      .TCK_DIV    (1),
      .DR_WIDTH   (8),
      .IR_WIDTH   (2),
      .RTI_CYCLES (1)
   ) dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid_b),
      .cmd_ready  (cmd_ready_b),
      .cmd_ir     (cmd_ir_b),
      .cmd_data   (cmd_data_b),
      .rsp_valid  (rsp_valid_b),
      .rsp_data   (rsp_data_b),
      .rsp_ir_out (rsp_ir_out_b),
      .vji_tck    (vji_tck_b),
      .vji_tdi    (vji_tdi_b),
      .vji_tdo    (vji_tdi_b),
      .vji_ir_in  (vji_ir_in_b),
      .vji_ir_out (ir_status),
      .vji_uir    (uir_b),
      .vji_cdr    (cdr_b),
      .vji_sdr    (sdr_b),
      .vji_udr    (udr_b),
      .vji_rti    (rti_b)
   );

   // Presents one command at a negedge; returns #1 into cycle 1 after the accept edge.
   task automatic accept_cmd(input logic [1:0] ir, input logic [37:0] data);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_ir    = ir;
      cmd_data  = data;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Steps from cycle 'start' until rsp_valid or 'limit', tallying strobe behaviour.
   task automatic wait_rsp(input int start, input int limit, output int cyc);
      logic [4:0] prev;
      n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0;
      onehot_bad = 0; tck_bad = 0; ready_bad = 0;
      cyc  = start;
      prev = strb;
      while (!rsp_valid && cyc < limit) begin
         n_uir += int'(vji_uir); n_cdr += int'(vji_cdr); n_sdr += int'(vji_sdr);
         n_udr += int'(vji_udr); n_rti += int'(vji_rti);
         if ($countones(strb) != 1) onehot_bad++;
         if (strb != prev && vji_tck) tck_bad++;
         if (cmd_ready) ready_bad++;
         prev = strb;
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
      checks++; if (rsp_data !== 38'h0) begin errors++; $display("FAIL rst_rsp_data got %h exp 0", rsp_data); end
      checks++; if (rsp_ir_out !== 2'b00) begin errors++; $display("FAIL rst_rsp_ir_out got %b exp 00", rsp_ir_out); end
      checks++; if ({vji_tck, vji_tdi, vji_ir_in} !== 4'b0000) begin errors++; $display("FAIL rst_tck_tdi_ir got %b exp 0000", {vji_tck, vji_tdi, vji_ir_in}); end
      checks++; if (strb !== 5'b00001) begin errors++; $display("FAIL rst_strobes got %b exp 00001", strb); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_idle();
      int tck_high = 0;
      int strb_bad = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         if (vji_tck) tck_high++;
         if (strb !== 5'b00001 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) strb_bad++;
      end
      checks++; if (tck_high !== 0) begin errors++; $display("FAIL idle_tck got %0d high cycles exp 0", tck_high); end
      checks++; if (strb_bad !== 0) begin errors++; $display("FAIL idle_outputs got %0d bad cycles exp 0", strb_bad); end
   endtask

   task automatic test_loopback();
      int cyc;
      ir_status = 2'b01;
      accept_cmd(IR_BREAK, CMD1);
      checks++; if (strb !== 5'b10000) begin errors++; $display("FAIL lb_cycle1_uir got %b exp 10000", strb); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL lb_ready_low got %b exp 0", cmd_ready); end
      checks++; if (vji_ir_in !== 2'b10) begin errors++; $display("FAIL lb_ir_in got %b exp 10", vji_ir_in); end
      wait_rsp(1, 400, cyc);
      checks++; if (cyc !== 173) begin errors++; $display("FAIL lb_latency got %0d exp 173", cyc); end
      checks++; if (rsp_data !== SLV_CAP) begin errors++; $display("FAIL lb_rsp_data got %h exp %h", rsp_data, SLV_CAP); end
      checks++; if (slv_sr !== CMD1) begin errors++; $display("FAIL lb_slave_sr got %h exp %h", slv_sr, CMD1); end
      checks++; if (rsp_ir_out !== 2'b01) begin errors++; $display("FAIL lb_rsp_ir_out got %b exp 01", rsp_ir_out); end
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL lb_ready_at_rsp got %b exp 1", cmd_ready); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL lb_rsp_pulse got %b exp 0", rsp_valid); end
      checks++; if (rsp_data !== SLV_CAP) begin errors++; $display("FAIL lb_rsp_hold got %h exp %h", rsp_data, SLV_CAP); end
      checks++; if (vji_ir_in !== 2'b10) begin errors++; $display("FAIL lb_ir_in_hold got %b exp 10", vji_ir_in); end
   endtask

   task automatic test_strobes();
      int cyc;
      accept_cmd(IR_OCIMEM, CMD2);
      wait_rsp(1, 400, cyc);
      checks++; if (n_uir !== 4) begin errors++; $display("FAIL st_uir got %0d exp 4", n_uir); end
      checks++; if (n_cdr !== 4) begin errors++; $display("FAIL st_cdr got %0d exp 4", n_cdr); end
      checks++; if (n_sdr !== 152) begin errors++; $display("FAIL st_sdr got %0d exp 152", n_sdr); end
      checks++; if (n_udr !== 4) begin errors++; $display("FAIL st_udr got %0d exp 4", n_udr); end
      checks++; if (n_rti !== 8) begin errors++; $display("FAIL st_rti got %0d exp 8", n_rti); end
      checks++; if (onehot_bad !== 0) begin errors++; $display("FAIL st_onehot got %0d bad exp 0", onehot_bad); end
      checks++; if (tck_bad !== 0) begin errors++; $display("FAIL st_change_tck_high got %0d exp 0", tck_bad); end
      checks++; if (ready_bad !== 0) begin errors++; $display("FAIL st_ready_busy got %0d exp 0", ready_bad); end
      checks++; if (strb !== 5'b00001) begin errors++; $display("FAIL st_rsp_rti got %b exp 00001", strb); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      ir_status = 2'b10;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_ir    = IR_BREAK;
      cmd_data  = CMD1;
      @(posedge clk);
      #1;
      cmd_ir   = IR_TRACEMEM;
      cmd_data = CMD2;
      for (int i = 1; i < 100; i++) begin
         @(posedge clk);
         #1;
      end
      ir_status = 2'b01;
      checks++; if (vji_ir_in !== 2'b10) begin errors++; $display("FAIL b2b_busy_ignored got %b exp 10", vji_ir_in); end
      wait_rsp(100, 400, cyc);
      checks++; if (cyc !== 173) begin errors++; $display("FAIL b2b_latency1 got %0d exp 173", cyc); end
      checks++; if (rsp_ir_out !== 2'b10) begin errors++; $display("FAIL b2b_ir_out1 got %b exp 10", rsp_ir_out); end
      checks++; if (slv_sr !== CMD1) begin errors++; $display("FAIL b2b_slave_sr1 got %h exp %h", slv_sr, CMD1); end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      checks++; if (vji_uir !== 1'b1 || vji_ir_in !== 2'b01) begin errors++; $display("FAIL b2b_second_accept got uir=%b ir=%b exp uir=1 ir=01", vji_uir, vji_ir_in); end
      wait_rsp(1, 400, cyc);
      checks++; if (cyc - 1 !== 172) begin errors++; $display("FAIL b2b_gap got %0d exp 172", cyc - 1); end
      checks++; if (rsp_data !== SLV_CAP) begin errors++; $display("FAIL b2b_rsp_data2 got %h exp %h", rsp_data, SLV_CAP); end
      checks++; if (rsp_ir_out !== 2'b01) begin errors++; $display("FAIL b2b_ir_out2 got %b exp 01", rsp_ir_out); end
      checks++; if (slv_sr !== CMD2) begin errors++; $display("FAIL b2b_slave_sr2 got %h exp %h", slv_sr, CMD2); end
   endtask

   task automatic test_reset_mid_scan();
      int cyc;
      int stray = 0;
      ir_status = 2'b11;
      accept_cmd(IR_OCIMEM, CMD1);
      for (int i = 1; i < 60; i++) begin
         @(posedge clk);
         #1;
      end
      checks++; if (vji_sdr !== 1'b1) begin errors++; $display("FAIL mid_in_sdr got %b exp 1", vji_sdr); end
      reset_n = 1'b0;
      #1;
      checks++; if ({cmd_ready, vji_tck, strb} !== 7'b1000001) begin errors++; $display("FAIL mid_async_reset got %b exp 1000001", {cmd_ready, vji_tck, strb}); end
      checks++; if (vji_ir_in !== 2'b00) begin errors++; $display("FAIL mid_ir_in_reset got %b exp 00", vji_ir_in); end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) stray++;
      end
      checks++; if (stray !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d pulses exp 0", stray); end
      accept_cmd(IR_TRACECTRL, CMD3);
      wait_rsp(1, 400, cyc);
      checks++; if (cyc !== 173) begin errors++; $display("FAIL mid_new_latency got %0d exp 173", cyc); end
      checks++; if (rsp_data !== SLV_CAP) begin errors++; $display("FAIL mid_new_rsp_data got %h exp %h", rsp_data, SLV_CAP); end
      checks++; if (slv_sr !== CMD3) begin errors++; $display("FAIL mid_new_slave_sr got %h exp %h", slv_sr, CMD3); end
      checks++; if (rsp_ir_out !== 2'b11) begin errors++; $display("FAIL mid_new_ir_out got %b exp 11", rsp_ir_out); end
   endtask

   task automatic test_div1();
      int cyc = 1;
      logic [1:0] tck_seq;
      @(negedge clk);
      cmd_valid_b = 1'b1;
      cmd_ir_b    = IR_TRACEMEM;
      cmd_data_b  = 8'hC5;
      @(posedge clk);
      #1;
      cmd_valid_b = 1'b0;
      tck_seq[0]  = vji_tck_b;
      @(posedge clk);
      #1;
      cyc++;
      tck_seq[1] = vji_tck_b;
      checks++; if (tck_seq !== 2'b10) begin errors++; $display("FAIL div1_tck_toggle got %b exp 10", tck_seq); end
      while (!rsp_valid_b && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      checks++; if (cyc !== 25) begin errors++; $display("FAIL div1_latency got %0d exp 25", cyc); end
      checks++; if (rsp_data_b !== 8'hC5) begin errors++; $display("FAIL div1_rsp_data got %h exp c5", rsp_data_b); end
      checks++; if (vji_ir_in_b !== 2'b01) begin errors++; $display("FAIL div1_ir_in got %b exp 01", vji_ir_in_b); end
      checks++; if (cmd_ready_b !== 1'b1 || rti_b !== 1'b1) begin errors++; $display("FAIL div1_idle got ready=%b rti=%b exp 1 1", cmd_ready_b, rti_b); end
   endtask

   initial begin
      reset_n     = 1'b0;
      cmd_valid   = 1'b0;
      cmd_ir      = 2'b00;
      cmd_data    = '0;
      cmd_valid_b = 1'b0;
      cmd_ir_b    = 2'b00;
      cmd_data_b  = '0;
      ir_status   = 2'b00;
      test_reset();
      test_idle();
      test_loopback();
      test_strobes();
      test_back_to_back();
      test_reset_mid_scan();
      test_div1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
